writeback_mem_stage: RTL and testbench

//  Stage 3 of the three-stage core. Consumes the execute->writeback pipeline register and

---
 rtl/writeback_mem_stage_pkg.sv | 72 +++++++
 rtl/writeback_mem_stage_if.sv | 23 ++
 rtl/writeback_mem_stage_load_align.sv | 34 +++
 rtl/writeback_mem_stage.sv | 150 +++++++++++++++
 tb/tb_writeback_mem_stage.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_mem_stage_pkg.sv
// Shared definitions for the writeback/memory stage.
//  - funct3 encodings for loads and stores
//  - FSM state and access-size enums
//  - store lane helper: byte enables plus lane-replicated write data
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wdata;
  } store_lane_t;

  // Undefined encodings fall back to a word access.
  function automatic size_e mem_size(input logic is_store, input logic [2:0] f3);
    size_e sz;
    if (is_store) begin
      case (f3)
        F3_SB:   sz = SZ_B;
        F3_SH:   sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: sz = SZ_B;
        F3_LH, F3_LHU: sz = SZ_H;
        default:       sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

  function automatic store_lane_t store_lane(input size_e sz, input logic [1:0] lane,
                                             input logic [31:0] data);
    store_lane_t sl;
    case (sz)
      SZ_B: begin
        sl.be    = 4'b0001 << lane;
        sl.wdata = {4{data[7:0]}};
      end
      SZ_H: begin
        sl.be    = 4'b0011 << lane;
        sl.wdata = {2{data[15:0]}};
      end
      default: begin
        sl.be    = 4'b1111;
        sl.wdata = data;
      end
    endcase
    return sl;
  endfunction

endpackage

// File: rtl/writeback_mem_stage_if.sv
// Data-memory req/gnt/rvalid bus.
//  master (stage): drives dmem_req/we/addr/be/wdata, receives dmem_gnt/rdata/rvalid
//  slave  (memory): the mirror image
interface writeback_mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rdata, dmem_rvalid
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rdata, dmem_rvalid
  );
endinterface

// File: rtl/writeback_mem_stage_load_align.sv
// Combinational load data alignment and extension.
//  rdata  in  32  raw word from memory
//  lane   in  2   address bits [1:0]
//  funct3 in  3   load size/sign encoding (unknown codes pass the word through)
//  data   out 32  aligned, sign- or zero-extended result
module load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shifted  = rdata >> {lane, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

  // Select the lane and extend according to the load type.
  always_comb begin
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'h000000, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'h0000, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_mem_stage.sv
// Stage 3 of the three-stage core: data-memory access and register writeback.
//  clk, reset          clock, asynchronous active-low reset
//  ex_*                execute->writeback pipeline register (held while stall_read=1)
//  dmem                data-memory bus (master side)
//  rf_we/waddr/wdata   register-file write port
//  stall_read          holds execute/fetch while a memory op is outstanding
//  misalign_err        pulse: misaligned access dropped
//  bus_err             pulse: access timed out and was dropped
// Outputs are combinational from the FSM state and the held ex_* inputs so that
// ALU writes and immediately granted stores complete in their own cycle.
module writeback_mem_stage
  import riscv_mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ex_valid,
  input  logic [31:0]              ex_result,
  input  logic [31:0]              ex_addr,
  input  logic                     ex_alu_to_reg,
  input  logic                     ex_mem_to_reg,
  input  logic                     ex_mem_write,
  input  logic [4:0]               ex_dest_reg,
  input  logic [2:0]               ex_funct3,
  writeback_mem_stage_if.master    dmem,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic                     stall_read,
  output logic                     misalign_err,
  output logic                     bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_e         state_r, state_nxt;
  logic [CNT_W-1:0] cnt_r;
  logic           is_mem;
  logic           misalign;
  logic           timeout_hit;
  size_e          size;
  store_lane_t    lane_st;
  logic [31:0]    load_data;

  assign is_mem      = ex_valid && (ex_mem_to_reg || ex_mem_write);
  assign size        = mem_size(ex_mem_write, ex_funct3);
  assign misalign    = ((size == SZ_H) && ex_addr[0]) ||
                       ((size == SZ_W) && (ex_addr[1:0] != 2'b00));
  assign timeout_hit = (cnt_r == CNT_W'(TIMEOUT - 1));
  assign lane_st     = store_lane(size, ex_addr[1:0], ex_result);

  load_align u_load_align (
    .rdata  (dmem.dmem_rdata),
    .lane   (ex_addr[1:0]),
    .funct3 (ex_funct3),
    .data   (load_data)
  );

  // Next state and all stage outputs; everything is held at zero during reset.
  always_comb begin
    state_nxt       = state_r;
    dmem.dmem_req   = 1'b0;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_addr  = 32'h0000_0000;
    dmem.dmem_be    = 4'b0000;
    dmem.dmem_wdata = 32'h0000_0000;
    rf_we           = 1'b0;
    rf_waddr        = 5'd0;
    rf_wdata        = 32'h0000_0000;
    stall_read      = 1'b0;
    misalign_err    = 1'b0;
    bus_err         = 1'b0;
    if (!reset) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_REQ: begin
          if (is_mem && misalign) begin
            misalign_err = 1'b1;
            state_nxt    = ST_IDLE;
          end else if (is_mem) begin
            dmem.dmem_req   = 1'b1;
            dmem.dmem_we    = ex_mem_write;
            dmem.dmem_addr  = {ex_addr[31:2], 2'b00};
            dmem.dmem_be    = ex_mem_write ? lane_st.be : 4'b1111;
            dmem.dmem_wdata = ex_mem_write ? lane_st.wdata : 32'h0000_0000;
            if (dmem.dmem_gnt) begin
              // Grant beats a same-cycle timeout.
              if (ex_mem_write) begin
                state_nxt = ST_IDLE;
              end else begin
                stall_read = 1'b1;
                state_nxt  = ST_WAIT;
              end
            end else if ((state_r == ST_REQ) && timeout_hit) begin
              bus_err   = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              stall_read = 1'b1;
              state_nxt  = ST_REQ;
            end
          end else if (ex_valid && (state_r == ST_IDLE)) begin
            rf_we     = ex_alu_to_reg && (ex_dest_reg != 5'd0);
            rf_waddr  = rf_we ? ex_dest_reg : 5'd0;
            rf_wdata  = rf_we ? ex_result : 32'h0000_0000;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (dmem.dmem_rvalid) begin
            rf_we     = (ex_dest_reg != 5'd0);
            rf_waddr  = rf_we ? ex_dest_reg : 5'd0;
            rf_wdata  = rf_we ? load_data : 32'h0000_0000;
            state_nxt = ST_IDLE;
          end else if (timeout_hit) begin
            bus_err   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            stall_read = 1'b1;
            state_nxt  = ST_WAIT;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State register and timeout counter; the counter restarts on every entry to REQ/WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt;
      if (state_nxt == ST_IDLE) begin
        cnt_r <= '0;
      end else if (state_nxt != state_r) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_writeback_mem_stage.sv
module tb_writeback_mem_stage;
  import riscv_mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_result;
  logic [31:0] ex_addr;
  logic        ex_alu_to_reg;
  logic        ex_mem_to_reg;
  logic        ex_mem_write;
  logic [4:0]  ex_dest_reg;
  logic [2:0]  ex_funct3;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_read;
  logic        misalign_err;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  writeback_mem_stage_if bus ();

  writeback_mem_stage #(.TIMEOUT(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_result     (ex_result),
    .ex_addr       (ex_addr),
    .ex_alu_to_reg (ex_alu_to_reg),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_mem_write  (ex_mem_write),
    .ex_dest_reg   (ex_dest_reg),
    .ex_funct3     (ex_funct3),
    .dmem          (bus),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .stall_read    (stall_read),
    .misalign_err  (misalign_err),
    .bus_err       (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid        = 1'b0;
    ex_result       = 32'h0;
    ex_addr         = 32'h0;
    ex_alu_to_reg   = 1'b0;
    ex_mem_to_reg   = 1'b0;
    ex_mem_write    = 1'b0;
    ex_dest_reg     = 5'd0;
    ex_funct3       = 3'd0;
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rdata  = 32'h0;
    bus.dmem_rvalid = 1'b0;
  endtask

  task automatic set_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
    ex_valid      = 1'b1;
    ex_alu_to_reg = 1'b1;
    ex_mem_to_reg = 1'b1;
    ex_mem_write  = 1'b0;
    ex_funct3     = f3;
    ex_addr       = addr;
    ex_dest_reg   = rd;
    ex_result     = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    ex_valid = 1'b1; ex_alu_to_reg = 1'b1; ex_dest_reg = 5'd5; ex_result = 32'h1234;
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we: got %b expected 0", rf_we); end
    total++; if (stall_read !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b expected 0", stall_read); end
    total++; if (bus.dmem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b expected 0", bus.dmem_req); end
    total++; if (rf_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h expected 0", rf_wdata); end
    step();
    reset = 1'b1;
    clear_inputs();
    step();
  endtask

  task automatic test_alu();
    ex_valid = 1'b1; ex_alu_to_reg = 1'b1; ex_dest_reg = 5'd5; ex_result = 32'h1234;
    @(negedge clk);
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL alu_we: got %b expected 1", rf_we); end
    total++; if (rf_waddr !== 5'd5) begin bad++; $display("FAIL alu_waddr: got %0d expected 5", rf_waddr); end
    total++; if (rf_wdata !== 32'h1234) begin bad++; $display("FAIL alu_wdata: got %h expected 00001234", rf_wdata); end
    total++; if (stall_read !== 1'b0 || bus.dmem_req !== 1'b0) begin bad++; $display("FAIL alu_nostall: got stall=%b req=%b expected 0 0", stall_read, bus.dmem_req); end
    step();
    ex_dest_reg = 5'd0;
    @(negedge clk);
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL alu_rd0_we: got %b expected 0", rf_we); end
    step();
    clear_inputs();
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [7] = '{F3_LB, F3_LBU, F3_LHU, F3_LH, F3_LB, F3_LW, F3_LBU};
    logic [31:0] ads [7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h104, 32'h101};
    logic [31:0] exp [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80AA, 32'hFFFF_80AA,
                             32'hFFFF_FFCC, 32'h80AA_BBCC, 32'h0000_00BB};
    for (int i = 0; i < 7; i++) begin
      set_load(f3s[i], ads[i], 5'd9);
      bus.dmem_gnt   = 1'b1;
      bus.dmem_rdata = 32'h80AA_BBCC;
      @(negedge clk);
      total++; if (bus.dmem_req !== 1'b1 || stall_read !== 1'b1 || rf_we !== 1'b0) begin bad++; $display("FAIL load%0d_issue: got req=%b stall=%b we=%b expected 1 1 0", i, bus.dmem_req, stall_read, rf_we); end
      total++; if (bus.dmem_be !== 4'b1111 || bus.dmem_addr !== {ads[i][31:2], 2'b00} || bus.dmem_we !== 1'b0) begin bad++; $display("FAIL load%0d_bus: got be=%b addr=%h we=%b", i, bus.dmem_be, bus.dmem_addr, bus.dmem_we); end
      step();
      bus.dmem_gnt    = 1'b0;
      bus.dmem_rvalid = 1'b1;
      @(negedge clk);
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || stall_read !== 1'b0) begin bad++; $display("FAIL load%0d_done: got we=%b waddr=%0d stall=%b expected 1 9 0", i, rf_we, rf_waddr, stall_read); end
      total++; if (rf_wdata !== exp[i]) begin bad++; $display("FAIL load%0d_data: got %h expected %h", i, rf_wdata, exp[i]); end
      step();
      clear_inputs();
    end
  endtask

  task automatic test_store_delay();
    int req_cycles = 0;
    int stall_cycles = 0;
    ex_valid = 1'b1; ex_mem_write = 1'b1; ex_funct3 = F3_SH;
    ex_addr = 32'h206; ex_result = 32'hDEAD_BEEF;
    for (int c = 0; c < 4; c++) begin
      bus.dmem_gnt = (c == 3);
      @(negedge clk);
      if (bus.dmem_req === 1'b1) req_cycles++;
      if (stall_read === 1'b1) stall_cycles++;
      total++; if (bus.dmem_be !== 4'b1100 || bus.dmem_wdata !== 32'hBEEF_BEEF || bus.dmem_addr !== 32'h204 || bus.dmem_we !== 1'b1) begin bad++; $display("FAIL sh_bus_c%0d: got be=%b wdata=%h addr=%h we=%b", c, bus.dmem_be, bus.dmem_wdata, bus.dmem_addr, bus.dmem_we); end
      total++; if (stall_read !== (c < 3)) begin bad++; $display("FAIL sh_stall_c%0d: got %b expected %b", c, stall_read, (c < 3)); end
      step();
    end
    total++; if (req_cycles != 4) begin bad++; $display("FAIL sh_req_cycles: got %0d expected 4", req_cycles); end
    total++; if (stall_cycles != 3) begin bad++; $display("FAIL sh_stall_cycles: got %0d expected 3", stall_cycles); end
    clear_inputs();
    // Byte store with immediate grant: no stall.
    ex_valid = 1'b1; ex_mem_write = 1'b1; ex_funct3 = F3_SB;
    ex_addr = 32'h101; ex_result = 32'h1234_5678; bus.dmem_gnt = 1'b1;
    @(negedge clk);
    total++; if (bus.dmem_be !== 4'b0010 || bus.dmem_wdata !== 32'h7878_7878 || stall_read !== 1'b0) begin bad++; $display("FAIL sb_imm: got be=%b wdata=%h stall=%b expected 0010 78787878 0", bus.dmem_be, bus.dmem_wdata, stall_read); end
    step();
    ex_funct3 = F3_SW; ex_addr = 32'h300;
    @(negedge clk);
    total++; if (bus.dmem_be !== 4'b1111 || bus.dmem_wdata !== 32'h1234_5678 || bus.dmem_addr !== 32'h300) begin bad++; $display("FAIL sw_imm: got be=%b wdata=%h addr=%h", bus.dmem_be, bus.dmem_wdata, bus.dmem_addr); end
    step();
    clear_inputs();
  endtask

  task automatic test_misalign();
    set_load(F3_LW, 32'h101, 5'd3);
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL lw_misalign_err: got %b expected 1", misalign_err); end
    total++; if (bus.dmem_req !== 1'b0 || rf_we !== 1'b0 || stall_read !== 1'b0) begin bad++; $display("FAIL lw_misalign_quiet: got req=%b we=%b stall=%b expected 0 0 0", bus.dmem_req, rf_we, stall_read); end
    step();
    clear_inputs();
    ex_valid = 1'b1; ex_mem_write = 1'b1; ex_funct3 = F3_SH; ex_addr = 32'h203; bus.dmem_gnt = 1'b1;
    @(negedge clk);
    total++; if (misalign_err !== 1'b1 || bus.dmem_req !== 1'b0) begin bad++; $display("FAIL sh_misalign: got err=%b req=%b expected 1 0", misalign_err, bus.dmem_req); end
    step();
    clear_inputs();
    @(negedge clk);
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL misalign_pulse_end: got %b expected 0", misalign_err); end
    step();
  endtask

  task automatic test_timeout(input logic late_win);
    set_load(F3_LW, 32'h400, 5'd7);
    bus.dmem_gnt   = 1'b1;
    bus.dmem_rdata = 32'hCAFE_F00D;
    step();
    bus.dmem_gnt = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 16 && late_win) bus.dmem_rvalid = 1'b1;
      @(negedge clk);
      if (k < 16) begin
        total++; if (stall_read !== 1'b1 || bus_err !== 1'b0 || bus.dmem_req !== 1'b0) begin bad++; $display("FAIL to_wait_k%0d: got stall=%b err=%b req=%b expected 1 0 0", k, stall_read, bus_err, bus.dmem_req); end
      end else if (late_win) begin
        total++; if (bus_err !== 1'b0 || rf_we !== 1'b1 || rf_wdata !== 32'hCAFE_F00D || stall_read !== 1'b0) begin bad++; $display("FAIL to_rvalid_wins: got err=%b we=%b wdata=%h stall=%b", bus_err, rf_we, rf_wdata, stall_read); end
      end else begin
        total++; if (bus_err !== 1'b1 || stall_read !== 1'b0 || rf_we !== 1'b0) begin bad++; $display("FAIL to_abort: got err=%b stall=%b we=%b expected 1 0 0", bus_err, stall_read, rf_we); end
      end
      step();
    end
    clear_inputs();
    bus.dmem_rvalid = 1'b1;
    @(negedge clk);
    total++; if (rf_we !== 1'b0 || stall_read !== 1'b0 || bus_err !== 1'b0) begin bad++; $display("FAIL to_late_rvalid: got we=%b stall=%b err=%b expected 0 0 0", rf_we, stall_read, bus_err); end
    step();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    set_load(F3_LW, 32'h500, 5'd4);
    bus.dmem_gnt = 1'b1;
    step();
    bus.dmem_gnt = 1'b0;
    @(negedge clk);
    total++; if (stall_read !== 1'b1) begin bad++; $display("FAIL rm_in_wait: got stall=%b expected 1", stall_read); end
    step();
    reset = 1'b0;
    #1;
    @(negedge clk);
    total++; if (stall_read !== 1'b0 || bus.dmem_req !== 1'b0 || rf_we !== 1'b0 || bus_err !== 1'b0 || misalign_err !== 1'b0) begin bad++; $display("FAIL rm_outputs: got stall=%b req=%b we=%b err=%b mis=%b expected all 0", stall_read, bus.dmem_req, rf_we, bus_err, misalign_err); end
    step();
    reset = 1'b1;
    clear_inputs();
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h1111_2222;
    @(negedge clk);
    total++; if (rf_we !== 1'b0 || stall_read !== 1'b0) begin bad++; $display("FAIL rm_stale_rvalid: got we=%b stall=%b expected 0 0", rf_we, stall_read); end
    step();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_store_delay();
    test_misalign();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
